fios_dsp_sequencer: RTL and testbench

Sequencer for one FIOS processing element's DSP multiply-accumulate slice: 17x17 multiplier, 34-bit C input, 34-bit P output, registered OPMODE. On a start request it issues operand word indices for an OUTER_CNT × WORD_CNT product schedule. It drives OPMODE and the C-register enable aligned to the slice's internal pipeline, and flags each valid P word. It sits between the PE's operand memories and the DSP slice, and replaces hand-timed OPMODE wiring in the PE.

---
 rtl/fios_dsp_pkg.sv | 30 +++
 rtl/fios_dsp_delay_pipe.sv | 54 +++++
 rtl/fios_dsp_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_fios_dsp_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fios_dsp_pkg.sv
// fios_dsp_pkg
//   Shared definitions for the FIOS DSP sequencer slice:
//   - OPMODE encodings driven onto the DSP slice (W[8:7] Z[6:4] Y[3:2] X[1:0])
//   - sequencer state type
//   - issue-to-P latency and index-width helpers
package fios_dsp_pkg;

  localparam logic [8:0] OPM_ZERO   = 9'h000;  // slice idle
  localparam logic [8:0] OPM_MC     = 9'h185;  // M + C
  localparam logic [8:0] OPM_MC_SHP = 9'h1E5;  // M + C + (P >> 17), carries into next word

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } seq_state_t;

  // Cycles from operand issue until the matching word is on P.
  function automatic int unsigned dsp_latency(input int unsigned abreg,
                                              input int unsigned mreg);
    return 1 + abreg + mreg;
  endfunction

  // Index width; a single-entry loop still gets a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fios_dsp_delay_pipe.sv
// fios_dsp_delay_pipe
//   Valid+data shift register of parameterised depth with asynchronous clear.
//   DEPTH=0 is a straight combinational pass-through.
// Ports:
//   clock_i    rising-edge clock
//   reset_n_i  asynchronous active-low clear of all stages
//   valid_i    valid entering the pipe
//   data_i     data entering the pipe (WIDTH bits)
//   valid_o    valid leaving the pipe, DEPTH cycles later
//   data_o     data leaving the pipe, DEPTH cycles later
module fios_dsp_delay_pipe #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  generate
    if (DEPTH == 0) begin : g_comb
      assign valid_o = valid_i;
      assign data_o  = data_i;

      // Clock and reset have no load in the pass-through build.
      logic unused_clk_rst;
      assign unused_clk_rst = clock_i ^ reset_n_i;
    end else begin : g_reg
      logic [DEPTH-1:0]            vld_q;
      logic [DEPTH-1:0][WIDTH-1:0] dat_q;

      always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          vld_q <= '0;
          dat_q <= '0;
        end else begin
          vld_q[0] <= valid_i;
          dat_q[0] <= data_i;
          for (int unsigned k = 1; k < DEPTH; k++) begin
            vld_q[k] <= vld_q[k-1];
            dat_q[k] <= dat_q[k-1];
          end
        end
      end

      assign valid_o = vld_q[DEPTH-1];
      assign data_o  = dat_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/fios_dsp_sequencer.sv
// fios_dsp_sequencer
//   Issues an OUTER_CNT x WORD_CNT operand schedule to one FIOS PE DSP slice
//   and drives OPMODE / C-register enable aligned to the slice pipeline,
//   flagging each valid P word and pulsing done after the last one.
// Parameters:
//   WORD_CNT  inner loop length (>=2)      OUTER_CNT  outer iterations (>=1)
//   ABREG     slice A/B stages (0..2)      MREG       slice M stages (0..1)
//   ABREG+MREG must be at least 1.
// Ports:
//   clock_i, reset_n_i      clock, asynchronous active-low reset
//   start_i                 start request, taken only while ready_o=1
//   ready_o                 idle, accepting start
//   issue_o, a_idx_o/b_idx_o  operands (j, i) to present to the slice this cycle
//   OPMODE_o, CREG_en_o     slice OPMODE and C-register enable
//   p_valid_o, p_a_idx_o/p_b_idx_o  slice P holds result for (j, i)
//   done_o                  one-cycle pulse after the last P word
// Optional build macro FIOS_DSP_SEQ_PERF_EN adds:
//   perf_cycles_o  non-IDLE cycles of the latest run (cleared on start accept)
//   perf_runs_o    completed runs, wrapping at 16 bits
module fios_dsp_sequencer
  import fios_dsp_pkg::*;
#(
  parameter int unsigned WORD_CNT  = 8,
  parameter int unsigned OUTER_CNT = 8,
  parameter int unsigned ABREG     = 1,
  parameter int unsigned MREG      = 1
) (
  input  logic                               clock_i,
  input  logic                               reset_n_i,
  input  logic                               start_i,
  output logic                               ready_o,
  output logic                               issue_o,
  output logic [idx_width(WORD_CNT)-1:0]     a_idx_o,
  output logic [idx_width(OUTER_CNT)-1:0]    b_idx_o,
  output logic [8:0]                         OPMODE_o,
  output logic                               CREG_en_o,
  output logic                               p_valid_o,
  output logic [idx_width(WORD_CNT)-1:0]     p_a_idx_o,
  output logic [idx_width(OUTER_CNT)-1:0]    p_b_idx_o,
`ifdef FIOS_DSP_SEQ_PERF_EN
  output logic [31:0]                        perf_cycles_o,
  output logic [15:0]                        perf_runs_o,
`endif
  output logic                               done_o
);

  localparam int unsigned AW            = idx_width(WORD_CNT);
  localparam int unsigned BW            = idx_width(OUTER_CNT);
  localparam int unsigned DSP_REG_LEVEL = dsp_latency(ABREG, MREG);
  localparam int unsigned OPM_DEPTH     = ABREG + MREG - 1;

  localparam logic [AW-1:0] J_LAST = AW'(WORD_CNT - 1);
  localparam logic [BW-1:0] I_LAST = BW'(OUTER_CNT - 1);
  // DSP_REG_LEVEL is at most 4, so the drain counter fits in 3 bits.
  localparam logic [2:0]    DRAIN_LOAD = 3'(DSP_REG_LEVEL - 1);

  seq_state_t state_q, state_d;

  logic [AW-1:0]    j_q;
  logic [BW-1:0]    i_q;
  logic [2:0]       drain_q;
  logic             last_issue;
  logic [8:0]       opm_issue;
  logic [AW+BW-1:0] p_idx_issue;

  assign last_issue = (state_q == ST_ISSUE) && (j_q == J_LAST) && (i_q == I_LAST);

  // State register
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_i)         state_d = ST_ISSUE;
      ST_ISSUE: if (last_issue)      state_d = ST_DRAIN;
      ST_DRAIN: if (drain_q == '0)   state_d = ST_DONE;
      ST_DONE:                       state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  // Output logic, plus the issue-stage values fed into the delay pipes
  always_comb begin
    ready_o     = 1'b0;
    issue_o     = 1'b0;
    done_o      = 1'b0;
    opm_issue   = OPM_ZERO;
    p_idx_issue = '0;
    unique case (state_q)
      ST_IDLE:  ready_o = 1'b1;
      ST_ISSUE: begin
        issue_o     = 1'b1;
        // First word of a row starts fresh; the rest fold in the carry word.
        opm_issue   = (j_q == '0) ? OPM_MC : OPM_MC_SHP;
        p_idx_issue = {i_q, j_q};
      end
      ST_DONE:  done_o = 1'b1;
      default:  ;
    endcase
  end

  // Word indices and drain counter. Indices return to zero on the last
  // issue so they read 0 whenever the sequencer is not issuing.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      j_q     <= '0;
      i_q     <= '0;
      drain_q <= '0;
    end else begin
      unique case (state_q)
        ST_ISSUE: begin
          if (last_issue) begin
            j_q     <= '0;
            i_q     <= '0;
            drain_q <= DRAIN_LOAD;
          end else if (j_q == J_LAST) begin
            j_q <= '0;
            i_q <= i_q + BW'(1);
          end else begin
            j_q <= j_q + AW'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_q != '0) drain_q <= drain_q - 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign a_idx_o = j_q;
  assign b_idx_o = i_q;

  // OPMODE reaches the slice's OPMODE register ABREG+MREG-1 cycles after issue.
  fios_dsp_delay_pipe #(
    .DEPTH (OPM_DEPTH),
    .WIDTH (9)
  ) u_opm_pipe (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .valid_i   (issue_o),
    .data_i    (opm_issue),
    .valid_o   (CREG_en_o),
    .data_o    (OPMODE_o)
  );

  // P word and its indices appear DSP_REG_LEVEL cycles after issue.
  fios_dsp_delay_pipe #(
    .DEPTH (DSP_REG_LEVEL),
    .WIDTH (AW + BW)
  ) u_p_pipe (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .valid_i   (issue_o),
    .data_i    (p_idx_issue),
    .valid_o   (p_valid_o),
    .data_o    ({p_b_idx_o, p_a_idx_o})
  );

`ifdef FIOS_DSP_SEQ_PERF_EN
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      perf_cycles_o <= '0;
      perf_runs_o   <= '0;
    end else begin
      if ((state_q == ST_IDLE) && start_i) begin
        perf_cycles_o <= '0;
      end else if (state_q != ST_IDLE) begin
        perf_cycles_o <= perf_cycles_o + 32'd1;
      end
      if (state_q == ST_DONE) begin
        perf_runs_o <= perf_runs_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fios_dsp_sequencer.sv
// tb_fios_dsp_sequencer
//   Two sequencer instances (ABREG=1/MREG=1 and ABREG=1/MREG=0, WORD_CNT=4,
//   OUTER_CNT=2) share start and reset. A cycle-indexed model per instance
//   gives every expected output from the number of cycles since start accept.
module tb_fios_dsp_sequencer;

  localparam int W = 4;
  localparam int O = 2;
  localparam int N = W * O;

  logic clock_i   = 1'b0;
  logic reset_n_i = 1'b1;
  logic start_i   = 1'b0;

  always #5 clock_i = ~clock_i;

  logic       d0_ready, d0_issue, d0_creg, d0_pv, d0_done;
  logic [1:0] d0_a, d0_pa;
  logic       d0_b, d0_pb;
  logic [8:0] d0_opm;
  logic       d1_ready, d1_issue, d1_creg, d1_pv, d1_done;
  logic [1:0] d1_a, d1_pa;
  logic       d1_b, d1_pb;
  logic [8:0] d1_opm;
`ifdef FIOS_DSP_SEQ_PERF_EN
  logic [31:0] d0_pcyc, d1_pcyc;
  logic [15:0] d0_pruns, d1_pruns;
`endif

  fios_dsp_sequencer #(
    .WORD_CNT (W), .OUTER_CNT (O), .ABREG (1), .MREG (1)
  ) u_dut0 (
    .clock_i (clock_i), .reset_n_i (reset_n_i), .start_i (start_i),
    .ready_o (d0_ready), .issue_o (d0_issue), .a_idx_o (d0_a), .b_idx_o (d0_b),
    .OPMODE_o (d0_opm), .CREG_en_o (d0_creg), .p_valid_o (d0_pv),
    .p_a_idx_o (d0_pa), .p_b_idx_o (d0_pb),
`ifdef FIOS_DSP_SEQ_PERF_EN
    .perf_cycles_o (d0_pcyc), .perf_runs_o (d0_pruns),
`endif
    .done_o (d0_done)
  );

  fios_dsp_sequencer #(
    .WORD_CNT (W), .OUTER_CNT (O), .ABREG (1), .MREG (0)
  ) u_dut1 (
    .clock_i (clock_i), .reset_n_i (reset_n_i), .start_i (start_i),
    .ready_o (d1_ready), .issue_o (d1_issue), .a_idx_o (d1_a), .b_idx_o (d1_b),
    .OPMODE_o (d1_opm), .CREG_en_o (d1_creg), .p_valid_o (d1_pv),
    .p_a_idx_o (d1_pa), .p_b_idx_o (d1_pb),
`ifdef FIOS_DSP_SEQ_PERF_EN
    .perf_cycles_o (d1_pcyc), .perf_runs_o (d1_pruns),
`endif
    .done_o (d1_done)
  );

  // Reference model: m_r = cycles since the accept edge (1 = first issue cycle)
  bit          m_act  [2];
  int          m_r    [2];
  int          m_lat  [2];
  logic [31:0] m_cyc  [2];
  logic [15:0] m_runs [2];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    else
      n_pass++;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_act[k]  = 1'b0;
      m_r[k]    = 0;
      m_cyc[k]  = '0;
      m_runs[k] = '0;
    end
  endtask

  task automatic model_edge(input logic st);
    for (int k = 0; k < 2; k++) begin
      if (m_act[k]) begin
        if (m_r[k] == N + m_lat[k] + 1) m_runs[k] = m_runs[k] + 16'd1;
        m_cyc[k] = m_cyc[k] + 32'd1;
        m_r[k]++;
        if (m_r[k] == N + m_lat[k] + 2) m_act[k] = 1'b0;
      end else if (st) begin
        m_act[k] = 1'b1;
        m_r[k]   = 1;
        m_cyc[k] = '0;
      end
    end
  endtask

  task automatic compare_inst(input int k, input logic rdy, input logic iss,
                              input logic [1:0] a, input logic b, input logic [8:0] opm,
                              input logic crg, input logic pv, input logic [1:0] pa,
                              input logic pb, input logic dn);
    int   r, lat, opd, wk, pk;
    logic e_iss, e_crg, e_pv, e_dn;
    int   e_a, e_b, e_pa, e_pb, e_opm;
    lat = m_lat[k];
    opd = lat - 2;
    r   = m_act[k] ? m_r[k] : -100;
    e_iss = (r >= 1) && (r <= N);
    e_a   = e_iss ? (r - 1) % W : 0;
    e_b   = e_iss ? (r - 1) / W : 0;
    wk    = r - 1 - opd;
    e_crg = (wk >= 0) && (wk < N);
    e_opm = !e_crg ? 'h000 : ((wk % W == 0) ? 'h185 : 'h1E5);
    pk    = r - 1 - lat;
    e_pv  = (pk >= 0) && (pk < N);
    e_pa  = e_pv ? pk % W : 0;
    e_pb  = e_pv ? pk / W : 0;
    e_dn  = (r == N + lat + 1);
    check($sformatf("u%0d.ready", k),  32'(rdy), 32'(!m_act[k]));
    check($sformatf("u%0d.issue", k),  32'(iss), 32'(e_iss));
    check($sformatf("u%0d.a_idx", k),  32'(a),   e_a);
    check($sformatf("u%0d.b_idx", k),  32'(b),   e_b);
    check($sformatf("u%0d.opmode", k), 32'(opm), e_opm);
    check($sformatf("u%0d.creg", k),   32'(crg), 32'(e_crg));
    check($sformatf("u%0d.pvalid", k), 32'(pv),  32'(e_pv));
    check($sformatf("u%0d.p_a", k),    32'(pa),  e_pa);
    check($sformatf("u%0d.p_b", k),    32'(pb),  e_pb);
    check($sformatf("u%0d.done", k),   32'(dn),  32'(e_dn));
  endtask

  task automatic compare_all();
    compare_inst(0, d0_ready, d0_issue, d0_a, d0_b, d0_opm, d0_creg, d0_pv, d0_pa, d0_pb, d0_done);
    compare_inst(1, d1_ready, d1_issue, d1_a, d1_b, d1_opm, d1_creg, d1_pv, d1_pa, d1_pb, d1_done);
`ifdef FIOS_DSP_SEQ_PERF_EN
    check("u0.perf_cycles", d0_pcyc,         m_cyc[0]);
    check("u0.perf_runs",   32'(d0_pruns),   32'(m_runs[0]));
    check("u1.perf_cycles", d1_pcyc,         m_cyc[1]);
    check("u1.perf_runs",   32'(d1_pruns),   32'(m_runs[1]));
`endif
  endtask

  // Drive inputs on the falling edge, compare just after, advance the model
  // on the rising edge the DUT samples.
  task automatic step(input logic st, input logic rn);
    @(negedge clock_i);
    start_i   = st;
    reset_n_i = rn;
    if (!rn) model_reset();
    #1;
    compare_all();
    @(posedge clock_i);
    if (reset_n_i) model_edge(start_i);
  endtask

  initial begin
    bit reached;
    m_lat[0] = 3;
    m_lat[1] = 2;
    model_reset();

    // Reset held for 3 cycles, then released
    repeat (3) step(1'b0, 1'b0);
    step(1'b0, 1'b1);

    // Single run followed by idle
    step(1'b1, 1'b1);
    repeat (16) step(1'b0, 1'b1);

    // Start held high: requests while busy are ignored, runs go back-to-back
    repeat (45) step(1'b1, 1'b1);

    // Reset during DRAIN of the ABREG=1/MREG=1 instance
    reached = 1'b0;
    for (int n = 0; n < 40 && !reached; n++) begin
      if (!m_act[0]) reached = 1'b1;
      else step(1'b0, 1'b1);
    end
    check("idle_wait", 32'(reached), 32'd1);
    step(1'b1, 1'b1);
    reached = 1'b0;
    for (int n = 0; n < 40 && !reached; n++) begin
      if (m_act[0] && m_r[0] == N + 2) reached = 1'b1;
      else step(1'b0, 1'b1);
    end
    check("drain_wait", 32'(reached), 32'd1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    repeat (20) step(1'b0, 1'b1);

    // Randomized start requests with occasional resets
    repeat (3000) step(1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 299) != 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
